// File: rtl/lcd_1602_monitor_if.sv
// rtl/lcd_1602_monitor_if.sv - HD44780-style 1602 write bus as seen by the driver and by snoopers
interface lcd_1602_monitor_if;
  logic       lcd_en;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  modport master (output lcd_en, output lcd_rw, output lcd_rs, output lcd_data);
  modport slave  (input  lcd_en, input  lcd_rw, input  lcd_rs, input  lcd_data);
endinterface

// File: rtl/lcd_1602_monitor.sv
// rtl/lcd_1602_monitor.sv - passive 1602 LCD bus snooper keeping a shadow of the 2x16 display
module lcd_1602_monitor #(
  parameter int         MIN_EN_HIGH = 4,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_1602_monitor_if.slave    bus,
  output logic [127:0]         row_1,
  output logic [127:0]         row_2,
  output logic [6:0]           cursor_addr,
  output logic                 disp_on,
  output logic                 init_done,
  output logic                 wr_stb,
  output logic                 last_rs,
  output logic [7:0]           last_byte
);

  localparam int CW = $clog2(MIN_EN_HIGH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_EN_HIGH);

  // bundle layout: {en, rw, rs, data}
  logic [10:0]   sync1_q, sync2_q;
  logic          en_dly_q;
  logic [CW-1:0] high_cnt_q;

  logic          s_en, s_rw, s_rs;
  logic [7:0]    s_data;
  logic          accept;

  logic [127:0]  row1_q, row1_d, row2_q, row2_d;
  logic [6:0]    cur_q, cur_d;
  logic          inc_q, inc_d, cg_q, cg_d;
  logic          disp_q, disp_d, init_q, init_d;
  logic          stb_q, stb_d, lrs_q, lrs_d;
  logic [7:0]    lb_q, lb_d;

  assign {s_en, s_rw, s_rs, s_data} = sync2_q;
  // Strobe only on a falling edge that followed a long-enough high pulse; reads are dropped here.
  assign accept = en_dly_q && !s_en && (high_cnt_q == CNT_MAX) && !s_rw;

  // Two-line DDRAM address map: 0x00-0x27 and 0x40-0x67, illegal gaps snap to the nearest line edge.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic illegal;
    illegal = (a >= 7'h28 && a <= 7'h3F) || (a >= 7'h68);
    if (up) begin
      if (a == 7'h27 || illegal) return 7'h40;
      else if (a == 7'h67)       return 7'h00;
      else                       return a + 7'd1;
    end else begin
      if (a == 7'h40 || illegal) return 7'h27;
      else if (a == 7'h00)       return 7'h67;
      else                       return a - 7'd1;
    end
  endfunction

  // Input synchronizer, edge-detect delay and glitch-filter high counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      en_dly_q   <= 1'b0;
      high_cnt_q <= '0;
    end else begin
      sync1_q  <= {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.lcd_data};
      sync2_q  <= sync1_q;
      en_dly_q <= s_en;
      if (!s_en)                   high_cnt_q <= '0;
      else if (high_cnt_q != CNT_MAX) high_cnt_q <= high_cnt_q + 1'b1;
    end
  end

  // Decode of one accepted write into next shadow state.
  always_comb begin
    row1_d = row1_q;
    row2_d = row2_q;
    cur_d  = cur_q;
    inc_d  = inc_q;
    cg_d   = cg_q;
    disp_d = disp_q;
    init_d = init_q;
    stb_d  = 1'b0;
    lrs_d  = lrs_q;
    lb_d   = lb_q;
    if (accept) begin
      stb_d = 1'b1;
      lrs_d = s_rs;
      lb_d  = s_data;
      if (!s_rs) begin
        casez (s_data)
          8'b1???????: begin cur_d = s_data[6:0]; cg_d = 1'b0; end
          8'b01??????: cg_d = 1'b1;
          8'b001?????: init_d = 1'b1;
          8'b0001????: if (!s_data[3]) cur_d = step_addr(cur_q, s_data[2]);
          8'b00001???: disp_d = s_data[2];
          8'b000001??: inc_d = s_data[1];
          8'b0000001?: cur_d = 7'h00;
          8'b00000001: begin
            row1_d = {16{BLANK_CHAR}};
            row2_d = {16{BLANK_CHAR}};
            cur_d  = 7'h00;
            inc_d  = 1'b1;
            cg_d   = 1'b0;
          end
          default: ;
        endcase
      end else if (!cg_q) begin
        // Column 0 sits in the top byte, so bit offset is (15 - col) * 8 = {~col, 3'b000}.
        if (cur_q[6:4] == 3'b000)      row1_d[{~cur_q[3:0], 3'b000} +: 8] = s_data;
        else if (cur_q[6:4] == 3'b100) row2_d[{~cur_q[3:0], 3'b000} +: 8] = s_data;
        cur_d = step_addr(cur_q, inc_q);
      end
    end
  end

  // Shadow state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      row1_q <= {16{BLANK_CHAR}};
      row2_q <= {16{BLANK_CHAR}};
      cur_q  <= 7'h00;
      inc_q  <= 1'b1;
      cg_q   <= 1'b0;
      disp_q <= 1'b0;
      init_q <= 1'b0;
      stb_q  <= 1'b0;
      lrs_q  <= 1'b0;
      lb_q   <= 8'h00;
    end else begin
      row1_q <= row1_d;
      row2_q <= row2_d;
      cur_q  <= cur_d;
      inc_q  <= inc_d;
      cg_q   <= cg_d;
      disp_q <= disp_d;
      init_q <= init_d;
      stb_q  <= stb_d;
      lrs_q  <= lrs_d;
      lb_q   <= lb_d;
    end
  end

  assign row_1       = row1_q;
  assign row_2       = row2_q;
  assign cursor_addr = cur_q;
  assign disp_on     = disp_q;
  assign init_done   = init_q;
  assign wr_stb      = stb_q;
  assign last_rs     = lrs_q;
  assign last_byte   = lb_q;

endmodule

// File: doc/lcd_1602_monitor.md
Name: lcd_1602_monitor

Overview:
- Passive receiver for the HD44780-style 1602 write bus produced by the team's LCD driver.
- Snoops lcd_en/lcd_rw/lcd_rs/lcd_data, decodes commands and data writes, and maintains a shadow of the visible 2x16 display.
- Used for on-chip loopback checking of the driver and for mirroring display content to other consumers such as UART dump or compare logic.
- Never drives the LCD bus.

Parameters:
- MIN_EN_HIGH, 4: minimum consecutive synchronized-high cycles of lcd_en before a falling edge is accepted as a write strobe (glitch filter).
- BLANK_CHAR, 8'h20: fill character used at reset and on clear display.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- lcd_en  input  1  LCD enable; a write is latched on the falling edge
- lcd_rw  input  1  0 = write, 1 = read (reads are ignored)
- lcd_rs  input  1  0 = command, 1 = data
- lcd_data  input  8  LCD data bus
- row_1  output  128  shadow of line 1; [127:120] = column 0 (leftmost), [7:0] = column 15
- row_2  output  128  shadow of line 2; same packing as row_1
- cursor_addr  output  7  current DDRAM address counter
- disp_on  output  1  display-on bit from the last display-control command
- init_done  output  1  set by the first function-set command; sticky until reset
- wr_stb  output  1  one-cycle pulse for each accepted write
- last_rs  output  1  rs of the last accepted write
- last_byte  output  8  data of the last accepted write

Behaviour:
- **Reset** (synchronous, priority over everything):
  - row_1 and row_2 = 16 x BLANK_CHAR.
  - cursor_addr = 0, internal inc = 1, internal cg_mode = 0.
  - disp_on, init_done, wr_stb, last_rs = 0; last_byte = 0.
  - Synchronizers and the filter counter are cleared.
  - Reset mid-stream discards any in-flight edge.
- **Input sync:** lcd_en, lcd_rw, lcd_rs and lcd_data pass through a 2-flop synchronizer as one bundle. A delayed copy of the synchronized lcd_en is used for edge detection.
- **High counter:** counts consecutive cycles with synced en = 1 and saturates at MIN_EN_HIGH. It clears on synced en = 0.
- **Accepted write:** delayed en = 1, synced en = 0, and high counter = MIN_EN_HIGH.
  - Uses the synced rw/rs/data of that same cycle.
  - Registered on the next edge. Outputs are visible after the 3rd rising edge, counting the first edge at which the pin is sampled low.
  - Falling edges after a shorter high pulse are ignored entirely.
- **Read access:** an accepted edge with rw = 1 has no effect; wr_stb stays 0.
- **On every accepted write (rw = 0):** wr_stb = 1 for one cycle; last_rs and last_byte are updated.
- **Command decode (rs = 0)**, by the highest set bit of data:
  - 0x01 clear: both rows set to BLANK_CHAR, cursor_addr = 0, inc = 1, cg_mode = 0.
  - 0x02–0x03 home: cursor_addr = 0.
  - 0x04–0x07 entry mode: inc = data[1]; data[0] (display shift) is ignored.
  - 0x08–0x0F display control: disp_on = data[2].
  - 0x10–0x1F shift: if data[3] = 0, the cursor moves by one step (right if data[2] = 1), using the wrap rules below. If data[3] = 1 (display shift), there is no state change.
  - 0x20–0x3F function set: init_done = 1.
  - 0x40–0x7F CGRAM address: cg_mode = 1.
  - 0x80–0xFF DDRAM address: cursor_addr = data[6:0], cg_mode = 0.
  - 0x00: no state change apart from wr_stb/last_*.
- **Data write (rs = 1):**
  - If cg_mode = 1: discard, and the address is unchanged.
  - Otherwise, the character is written according to cursor_addr:
    - 0x00–0x0F: written to row_1 column cursor_addr.
    - 0x40–0x4F: written to row_2 column cursor_addr − 0x40.
    - Any other address: no visible change.
  - After the write, the address advances one step per inc.
- **Address step / wrap (2-line map):**
  - Increment: 0x27 → 0x40 and 0x67 → 0x00; otherwise +1.
  - Decrement: 0x00 → 0x67 and 0x40 → 0x27; otherwise −1.
  - An illegal cursor_addr (0x28–0x3F, 0x68–0x7F) steps to 0x40 on increment and 0x27 on decrement.
- **Back-to-back writes:** one write is processed per accepted edge. Since MIN_EN_HIGH ≥ 1, two writes can never collide.

Test Plan:
- Reset, then hold pins idle → row_1 = row_2 = 128'h2020…20, cursor_addr = 0, disp_on = 0, init_done = 0, wr_stb never asserts.
- Init sequence rs = 0: 0x38, 0x08, 0x01, 0x06, 0x0C, with en high 50 cycles each → init_done = 1, disp_on = 1, cursor_addr = 0, five wr_stb pulses, last_byte = 0x0C. Check wr_stb latency is exactly 3 edges after en is sampled low.
- Address and data:
  - cmd 0x80, then data 0x31, 0x32 → row_1[127:112] = 16'h3132, cursor_addr = 2.
  - cmd 0xC0, then 16 data bytes 0x41..0x50 → row_2 = "ABCDEFGHIJKLMNOP", cursor_addr = 0x50.
- Wrap:
  - cmd 0xA7, data 0x58 → no visible change, cursor_addr = 0x40.
  - cmd 0x04 (dec), cmd 0x80, data 0x5A → row_1 col 0 = 0x5A, cursor_addr = 0x67.
- Filtering:
  - en high 2 cycles then low, with rs = 1 and data 0x33 → no wr_stb, rows unchanged.
  - rw = 1 with en high 50 cycles → no wr_stb, no state change.
- CGRAM and clear:
  - cmd 0x40, data 0x7E → discarded (rows unchanged, cursor_addr unchanged).
  - cmd 0x85, data 0x7E → row_1 col 5 = 0x7E.
  - cmd 0x01 → all blank, cursor_addr = 0.
  - Assert reset one cycle after an en falling edge → no wr_stb, all reset values.
